// File: rtl/wishbone_uart_tx_slave.sv
// Wishbone classic slave that buffers console bytes in a FIFO and drains them into uart_tx.
// Optional WB_UART_TX_HEX_EN adds a register that pushes a byte as two ASCII hex characters.
module wishbone_uart_tx_slave #(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter logic [31:0] TXDATA_ADDR = 32'h0,
    parameter logic [31:0] STATUS_ADDR = 32'h4,
    parameter logic [31:0] CTRL_ADDR   = 32'h8,
    parameter logic [31:0] HEX_ADDR    = 32'hC
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [63:0] data_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    output logic [63:0] data_o,
    output logic        ack_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_data_valid_o,
    input  logic        tx_data_ready_i
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [1:0] {IDLE, PRESENT, GAP} state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wptr, rptr, level;
    logic          empty, full, overflow, armed;
    logic          accept, wr_txdata, flush, clr_ovf, room1, push1, pop;
    logic [63:0]   rdata;
    state_t        state, state_nxt;
    logic          valid_nxt;
    logic [7:0]    data_nxt;

    assign accept    = cyc_i & stb_i & armed;
    assign wr_txdata = accept & we_i & (addr_i == TXDATA_ADDR);
    assign flush     = accept & we_i & (addr_i == CTRL_ADDR) & data_i[0];
    assign clr_ovf   = accept & we_i & (addr_i == CTRL_ADDR) & data_i[1];

    assign level = wptr - rptr;
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    // A pop on the same edge frees a slot, so a full FIFO still accepts a push.
    assign room1 = ~full | pop;
    assign push1 = wr_txdata & room1;

`ifdef WB_UART_TX_HEX_EN
    localparam int unsigned LW = AW + 2;
    logic          wr_hex, room2, push2;
    logic [LW-1:0] avail;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign wr_hex = accept & we_i & (addr_i == HEX_ADDR);
    assign avail  = LW'(FIFO_DEPTH) - LW'(level) + LW'(pop);
    assign room2  = (avail >= LW'(2));
    assign push2  = wr_hex & room2;
`else
    logic unused_hex;
    assign unused_hex = ^HEX_ADDR;
`endif

    logic unused_bits;
    assign unused_bits = ^data_i[63:8];

    assign rdata = (addr_i == STATUS_ADDR)
                 ? {48'b0, 8'(level), 5'b0, overflow, empty, full}
                 : 64'h0;

    // Bus handshake: one access per strobe, re-armed once stb drops.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            armed  <= 1'b1;
            ack_o  <= 1'b0;
            data_o <= 64'h0;
        end else begin
            ack_o  <= accept;
            data_o <= (accept & ~we_i) ? rdata : 64'h0;
            if (accept)
                armed <= 1'b0;
            else if (!stb_i)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push1)
            mem[wptr[AW-1:0]] <= data_i[7:0];
`ifdef WB_UART_TX_HEX_EN
        if (push2) begin
            mem[wptr[AW-1:0]]              <= hex_char(data_i[7:4]);
            mem[wptr[AW-1:0] + AW'(1)]     <= hex_char(data_i[3:0]);
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else begin
            if (flush) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (pop)
                    rptr <= rptr + PW'(1);
                if (push1)
                    wptr <= wptr + PW'(1);
                else if (wr_txdata)
                    overflow <= 1'b1;
`ifdef WB_UART_TX_HEX_EN
                if (push2)
                    wptr <= wptr + PW'(2);
                else if (wr_hex)
                    overflow <= 1'b1;
`endif
            end
            if (clr_ovf)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= IDLE;
            tx_data_valid_o <= 1'b0;
            tx_data_o       <= 8'h0;
        end else begin
            state           <= state_nxt;
            tx_data_valid_o <= valid_nxt;
            tx_data_o       <= data_nxt;
        end
    end

    // Drain FSM: present head byte, pop on ready, then one idle gap cycle.
    always_comb begin
        state_nxt = state;
        valid_nxt = tx_data_valid_o;
        data_nxt  = tx_data_o;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_nxt = PRESENT;
                    valid_nxt = 1'b1;
                    data_nxt  = mem[rptr[AW-1:0]];
                end
            end
            PRESENT: begin
                if (tx_data_ready_i) begin
                    pop       = 1'b1;
                    valid_nxt = 1'b0;
                    state_nxt = GAP;
                end
            end
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_wishbone_uart_tx_slave.sv
// Directed bench for wishbone_uart_tx_slave: vector table plus multi-cycle corner sequences.
// Builds with or without WB_UART_TX_HEX_EN.
module tb_wishbone_uart_tx_slave;

    localparam logic [31:0] A_TX   = 32'h0;
    localparam logic [31:0] A_ST   = 32'h4;
    localparam logic [31:0] A_CTRL = 32'h8;
    localparam logic [31:0] A_HEX  = 32'hC;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] addr_i;
    logic        we_i;
    logic [63:0] data_i;
    logic        cyc_i;
    logic        stb_i;
    logic [63:0] data_o;
    logic        ack_o;
    logic [7:0]  tx_data_o;
    logic        tx_data_valid_o;
    logic        tx_data_ready_i;

    int n_vec  = 0;
    int n_fail = 0;
    logic valid_at_ack;
    logic [7:0] sent[$];

    always #5 clk_i = ~clk_i;

    wishbone_uart_tx_slave dut (
        .clk_i(clk_i), .rst_i(rst_i), .addr_i(addr_i), .we_i(we_i), .data_i(data_i),
        .cyc_i(cyc_i), .stb_i(stb_i), .data_o(data_o), .ack_o(ack_o),
        .tx_data_o(tx_data_o), .tx_data_valid_o(tx_data_valid_o),
        .tx_data_ready_i(tx_data_ready_i)
    );

    // Bytes handed to uart_tx on each valid & ready edge.
    always @(posedge clk_i)
        if (!rst_i && tx_data_valid_o && tx_data_ready_i)
            sent.push_back(tx_data_o);

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rd;
        logic        exp_valid;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [63:0] d);
        addr_i = a; data_i = d; we_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1;
        tick();
        check("wr_ack", 64'(ack_o), 64'h1);
        valid_at_ack = tx_data_valid_o;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        tick();
        check("wr_ack_drop", 64'(ack_o), 64'h0);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [63:0] d);
        addr_i = a; we_i = 1'b0; cyc_i = 1'b1; stb_i = 1'b1;
        tick();
        check("rd_ack", 64'(ack_o), 64'h1);
        d = data_o;
        cyc_i = 1'b0; stb_i = 1'b0;
        tick();
        check("rd_data_drop", data_o, 64'h0);
    endtask

    task automatic wait_sent(input int n);
        for (int c = 0; c < 400 && sent.size() < n; c++)
            tick();
        check("sent_count", 64'(sent.size()), 64'(n));
    endtask

    initial begin
        logic [63:0] rd;
        int acks;
        logic [7:0] expq[$];

        rst_i = 1'b1; addr_i = '0; we_i = 1'b0; data_i = '0;
        cyc_i = 1'b0; stb_i = 1'b0; tx_data_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        check("rst_ack", 64'(ack_o), 64'h0);
        check("rst_data", data_o, 64'h0);
        check("rst_txd", 64'(tx_data_o), 64'h0);
        check("rst_valid", 64'(tx_data_valid_o), 64'h0);

        // Vector table: fill, overflow, clear, unmapped, flush with ready held low.
        vecs.push_back('{1'b0, A_ST,   64'h0, 64'h2, 1'b0});
        vecs.push_back('{1'b0, A_TX,   64'h0, 64'h0, 1'b0});
        vecs.push_back('{1'b0, A_CTRL, 64'h0, 64'h0, 1'b0});
        vecs.push_back('{1'b0, 32'h10, 64'h0, 64'h0, 1'b0});
        for (int i = 0; i < 16; i++)
            vecs.push_back('{1'b1, A_TX, 64'(8'h30 + i), 64'h0, 1'b1});
        vecs.push_back('{1'b0, A_ST,   64'h0,  64'h1001, 1'b1});
        vecs.push_back('{1'b1, A_TX,   64'h99, 64'h0,    1'b1});
        vecs.push_back('{1'b0, A_ST,   64'h0,  64'h1005, 1'b1});
        vecs.push_back('{1'b1, A_CTRL, 64'h2,  64'h0,    1'b1});
        vecs.push_back('{1'b0, A_ST,   64'h0,  64'h1001, 1'b1});
        vecs.push_back('{1'b1, 32'h20, 64'hFF, 64'h0,    1'b1});
        vecs.push_back('{1'b0, A_ST,   64'h0,  64'h1001, 1'b1});
        vecs.push_back('{1'b0, A_HEX,  64'h0,  64'h0,    1'b1});
        vecs.push_back('{1'b1, A_CTRL, 64'h1,  64'h0,    1'b0});
        vecs.push_back('{1'b0, A_ST,   64'h0,  64'h2,    1'b0});

        foreach (vecs[i]) begin
            if (vecs[i].we) begin
                bus_write(vecs[i].addr, vecs[i].wdata);
            end else begin
                bus_read(vecs[i].addr, rd);
                check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
            end
            check($sformatf("vec%0d_valid", i), 64'(tx_data_valid_o), 64'(vecs[i].exp_valid));
            if (vecs[i].exp_valid)
                check($sformatf("vec%0d_txd", i), 64'(tx_data_o), 64'h30);
        end
        check("tbl_nothing_sent", 64'(sent.size()), 64'h0);

        // Single byte through to uart_tx with ready high.
        tx_data_ready_i = 1'b1;
        bus_write(A_TX, 64'h41);
        check("t1_valid", 64'(tx_data_valid_o), 64'h1);
        check("t1_txd", 64'(tx_data_o), 64'h41);
        tick();
        tick();
        check("t1_valid_low", 64'(tx_data_valid_o), 64'h0);
        check("t1_sent_n", 64'(sent.size()), 64'h1);
        if (sent.size() > 0) check("t1_sent_byte", 64'(sent[0]), 64'h41);
        bus_read(A_ST, rd);
        check("t1_status", rd, 64'h2);

        // Strobe held for 5 cycles: exactly one ack and one push.
        tx_data_ready_i = 1'b0;
        acks = 0;
        addr_i = A_TX; data_i = 64'h55; we_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            acks += int'(ack_o);
        end
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        tick();
        check("long_stb_acks", 64'(acks), 64'h1);
        bus_read(A_ST, rd);
        check("long_stb_level", rd, 64'h100);
        bus_write(A_CTRL, 64'h1);

        // Full FIFO with a push on the same edge as a transfer.
        sent.delete();
        for (int i = 0; i < 16; i++)
            bus_write(A_TX, 64'(8'h60 + i));
        addr_i = A_TX; data_i = 64'h70; we_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1;
        tx_data_ready_i = 1'b1;
        tick();
        check("coin_ack", 64'(ack_o), 64'h1);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        tx_data_ready_i = 1'b0;
        tick();
        bus_read(A_ST, rd);
        check("coin_status", rd, 64'h1001);
        tx_data_ready_i = 1'b1;
        wait_sent(17);
        for (int i = 0; i < 16; i++) expq.push_back(8'h60 + 8'(i));
        expq.push_back(8'h70);
        foreach (expq[i])
            if (i < sent.size())
                check($sformatf("coin_order%0d", i), 64'(sent[i]), 64'(expq[i]));
        tick();
        bus_read(A_ST, rd);
        check("coin_drained", rd, 64'h2);

        // Flush while a byte is presented and ready is low.
        tx_data_ready_i = 1'b0;
        sent.delete();
        for (int i = 0; i < 3; i++)
            bus_write(A_TX, 64'(8'h21 + i));
        check("fl_valid_before", 64'(tx_data_valid_o), 64'h1);
        bus_write(A_CTRL, 64'h1);
        check("fl_valid_after", 64'(valid_at_ack), 64'h0);
        bus_read(A_ST, rd);
        check("fl_status", rd, 64'h2);
        tx_data_ready_i = 1'b1;
        repeat (6) tick();
        check("fl_none_sent", 64'(sent.size()), 64'h0);

`ifdef WB_UART_TX_HEX_EN
        bus_write(A_HEX, 64'h3C);
        wait_sent(2);
        if (sent.size() == 2) begin
            check("hex_hi", 64'(sent[0]), 64'h33);
            check("hex_lo", 64'(sent[1]), 64'h43);
        end
        tx_data_ready_i = 1'b0;
        for (int i = 0; i < 15; i++)
            bus_write(A_TX, 64'(8'h40 + i));
        bus_write(A_HEX, 64'hA5);
        bus_read(A_ST, rd);
        check("hex_drop", rd, 64'hF04);
        bus_write(A_CTRL, 64'h3);
        bus_read(A_ST, rd);
        check("hex_cleared", rd, 64'h2);
`else
        bus_write(A_HEX, 64'h3C);
        repeat (8) tick();
        check("hex_unmapped_sent", 64'(sent.size()), 64'h0);
        bus_read(A_ST, rd);
        check("hex_unmapped_st", rd, 64'h2);
`endif

        // Reset in the middle of a presented byte.
        tx_data_ready_i = 1'b0;
        bus_write(A_TX, 64'h7E);
        bus_write(A_TX, 64'h7F);
        check("mid_valid", 64'(tx_data_valid_o), 64'h1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("mid_rst_valid", 64'(tx_data_valid_o), 64'h0);
        check("mid_rst_txd", 64'(tx_data_o), 64'h0);
        bus_read(A_ST, rd);
        check("mid_rst_status", rd, 64'h2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
